// File: rtl/mem_access_unit_if.sv
// rtl/mem_access_unit_if.sv - single-outstanding request/acknowledge data bus
interface mem_access_unit_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
);
    logic                  req;
    logic                  we;
    logic [ADDR_WIDTH-1:0] addr;
    logic [3:0]            be;
    logic [DATA_WIDTH-1:0] wdata;
    logic                  ack;
    logic [DATA_WIDTH-1:0] rdata;

    modport master (output req, we, addr, be, wdata, input ack, rdata);
    modport slave  (input req, we, addr, be, wdata, output ack, rdata);
endinterface

// File: rtl/mem_access_unit.sv
// rtl/mem_access_unit.sv - MEM-stage controller: lane mapping, load extension, bus handshake
// Optional bus watchdog enabled by defining MEM_TIMEOUT_EN.
module mem_access_unit #(
    parameter int ADDR_WIDTH     = 32,
    parameter int DATA_WIDTH     = 32,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  flush,
    input  logic [ADDR_WIDTH-1:0] addr_in,
    input  logic [DATA_WIDTH-1:0] wdata_in,
    input  logic [1:0]            mem_width_in,
    input  logic                  sign_extend_in,
    input  logic                  mem_rw_in,
    input  logic                  mem_enable_in,
    output logic                  stall_out,
    output logic                  addr_error_out,
    output logic                  done_out,
    output logic [DATA_WIDTH-1:0] rdata_out,
    mem_access_unit_if.master     bus,
    output logic                  bus_err_out
);
    typedef enum logic [1:0] {IDLE, WAIT, DONE} state_t;

    state_t                state_q;
    logic                  req_q, we_q, sign_q, squash_q, done_q, err_q;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic [3:0]            be_q, be_d;
    logic [DATA_WIDTH-1:0] wdata_q, wdata_d, rdata_q, lane, load_d;
    logic [1:0]            width_q;
    logic                  misaligned, start, squash_now, timeout;

    always_comb begin
        misaligned = 1'b0;
        be_d       = 4'b1111;
        wdata_d    = wdata_in;
        unique case (mem_width_in)
            2'd0: begin
                be_d    = 4'b0001 << addr_in[1:0];
                wdata_d = {4{wdata_in[7:0]}};
            end
            2'd1: begin
                misaligned = addr_in[0];
                be_d       = addr_in[1] ? 4'b1100 : 4'b0011;
                wdata_d    = {2{wdata_in[15:0]}};
            end
            default: misaligned = |addr_in[1:0];
        endcase
        if (!mem_rw_in) wdata_d = '0;
    end

    // Lane extraction works on the latched request so the result is independent of the pipeline inputs.
    always_comb begin
        lane = bus.rdata >> {addr_q[1:0], 3'b000};
        unique case (width_q)
            2'd0:    load_d = {{24{sign_q & lane[7]}}, lane[7:0]};
            2'd1:    load_d = {{16{sign_q & lane[15]}}, lane[15:0]};
            default: load_d = lane;
        endcase
        if (we_q) load_d = '0;
    end

    assign start          = (state_q == IDLE) && mem_enable_in && !flush && !misaligned;
    assign addr_error_out = (state_q == IDLE) && mem_enable_in && !flush && misaligned;
    assign stall_out      = start || (state_q == WAIT);
    assign squash_now     = squash_q || flush;

`ifdef MEM_TIMEOUT_EN
    localparam logic [15:0] TO_LAST = 16'(TIMEOUT_CYCLES - 1);
    logic [15:0] cnt_q;
    assign timeout = (cnt_q == TO_LAST);
`else
    assign timeout = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            req_q    <= 1'b0;
            we_q     <= 1'b0;
            sign_q   <= 1'b0;
            squash_q <= 1'b0;
            done_q   <= 1'b0;
            err_q    <= 1'b0;
            addr_q   <= '0;
            be_q     <= '0;
            wdata_q  <= '0;
            rdata_q  <= '0;
            width_q  <= '0;
`ifdef MEM_TIMEOUT_EN
            cnt_q    <= '0;
`endif
        end else begin
            done_q <= 1'b0;
            err_q  <= 1'b0;
            unique case (state_q)
                IDLE: begin
                    squash_q <= 1'b0;
                    if (start) begin
                        state_q <= WAIT;
                        req_q   <= 1'b1;
                        we_q    <= mem_rw_in;
                        sign_q  <= sign_extend_in;
                        addr_q  <= addr_in;
                        be_q    <= be_d;
                        wdata_q <= wdata_d;
                        width_q <= mem_width_in;
`ifdef MEM_TIMEOUT_EN
                        cnt_q   <= '0;
`endif
                    end
                end
                WAIT: begin
                    if (flush) squash_q <= 1'b1;
                    if (bus.ack) begin
                        state_q <= DONE;
                        req_q   <= 1'b0;
                        done_q  <= !squash_now;
                        rdata_q <= squash_now ? '0 : load_d;
                    end else if (timeout) begin
                        state_q <= DONE;
                        req_q   <= 1'b0;
                        done_q  <= !squash_now;
                        rdata_q <= '0;
                        err_q   <= 1'b1;
                    end
`ifdef MEM_TIMEOUT_EN
                    else begin
                        cnt_q <= cnt_q + 16'd1;
                    end
`endif
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign done_out    = done_q;
    assign rdata_out   = rdata_q;
    assign bus_err_out = err_q;
    assign bus.req     = req_q;
    assign bus.we      = we_q;
    assign bus.addr    = {addr_q[ADDR_WIDTH-1:2], 2'b00};
    assign bus.be      = be_q;
    assign bus.wdata   = wdata_q;
endmodule

// File: tb/tb_mem_access_unit.sv
// tb/tb_mem_access_unit.sv - randomized self-checking bench for mem_access_unit
module tb_mem_access_unit;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        flush = 1'b0;
    logic [31:0] addr_in = '0, wdata_in = '0;
    logic [1:0]  mem_width_in = '0;
    logic        sign_extend_in = 1'b0, mem_rw_in = 1'b0, mem_enable_in = 1'b0;
    logic        stall_out, addr_error_out, done_out, bus_err_out;
    logic [31:0] rdata_out;
    int          tests = 0, fails = 0;

    always #5 clk = ~clk;

    mem_access_unit_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) bus_if ();

    mem_access_unit #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .TIMEOUT_CYCLES(4)) dut (
        .clk(clk), .rst_n(rst_n), .flush(flush), .addr_in(addr_in), .wdata_in(wdata_in),
        .mem_width_in(mem_width_in), .sign_extend_in(sign_extend_in), .mem_rw_in(mem_rw_in),
        .mem_enable_in(mem_enable_in), .stall_out(stall_out), .addr_error_out(addr_error_out),
        .done_out(done_out), .rdata_out(rdata_out), .bus(bus_if), .bus_err_out(bus_err_out)
    );

    // Reference: access size in bytes, lane offset, and plain masking/shifting.
    function automatic void model(input logic [31:0] a, input logic [31:0] wd, input logic [1:0] w,
                                  input logic se, input logic rw, input logic [31:0] rd,
                                  output logic mis, output logic [3:0] be,
                                  output logic [31:0] wrep, output logic [31:0] rres);
        int n, k;
        logic [63:0] m, v;
        n = (w == 2'd0) ? 1 : (w == 2'd1) ? 2 : 4;
        k = int'(a % 4);
        mis = (a % n) != 0;
        be = 4'(((1 << n) - 1) << k);
        wrep = '0;
        if (rw) for (int i = 0; i < 4; i++) wrep[i*8 +: 8] = wd[(i % n)*8 +: 8];
        m = (64'd1 << (8*n)) - 64'd1;
        v = ({32'd0, rd} >> (8*k)) & m;
        if (se && v[8*n-1]) v = v | ~m;
        rres = rw ? 32'd0 : v[31:0];
    endfunction

    task automatic do_access(input logic [31:0] a, input logic [31:0] wd, input logic [1:0] w,
                             input logic se, input logic rw, input logic [31:0] rd,
                             input int delay, input int flush_at, input string nm);
        logic mis;
        logic [3:0] ebe;
        logic [31:0] ewd, erd;
        int stalls;
        model(a, wd, w, se, rw, rd, mis, ebe, ewd, erd);
        @(negedge clk);
        addr_in = a; wdata_in = wd; mem_width_in = w; sign_extend_in = se; mem_rw_in = rw;
        mem_enable_in = 1'b1; flush = 1'b0; bus_if.ack = 1'b0;
        #1;
        tests++;
        if (addr_error_out !== mis) begin
            fails++; $display("FAIL %s addr_error: got %b expected %b", nm, addr_error_out, mis);
        end
        if (mis) begin
            tests++;
            if (stall_out !== 1'b0) begin fails++; $display("FAIL %s mis_stall: got %b expected 0", nm, stall_out); end
            @(negedge clk); #1;
            tests++;
            if ({bus_if.req, stall_out} !== 2'b00) begin
                fails++; $display("FAIL %s mis_req: got req=%b stall=%b expected 0 0", nm, bus_if.req, stall_out);
            end
            mem_enable_in = 1'b0;
            return;
        end
        stalls = stall_out ? 1 : 0;
        for (int c = 0; c <= delay; c++) begin
            @(negedge clk);
            flush = (c == flush_at);
            bus_if.ack = (c == delay);
            bus_if.rdata = (c == delay) ? rd : $urandom;
            #1;
            if (stall_out) stalls++;
            tests++;
            if ({bus_if.req, bus_if.we, bus_if.addr, bus_if.be, bus_if.wdata} !==
                {1'b1, rw, a[31:2], 2'b00, ebe, ewd}) begin
                fails++;
                $display("FAIL %s bus wait%0d: got req=%b we=%b addr=%h be=%b wdata=%h expected 1 %b %h %b %h",
                         nm, c, bus_if.req, bus_if.we, bus_if.addr, bus_if.be, bus_if.wdata,
                         rw, {a[31:2], 2'b00}, ebe, ewd);
            end
        end
        @(negedge clk);
        bus_if.ack = 1'b0; flush = 1'b0;
        #1;
        if (flush_at >= 0) erd = '0;
        tests++;
        if ({done_out, rdata_out, stall_out, bus_if.req, bus_err_out} !== {flush_at < 0, erd, 3'b000}) begin
            fails++;
            $display("FAIL %s done: got done=%b rdata=%h stall=%b req=%b err=%b expected %b %h 0 0 0",
                     nm, done_out, rdata_out, stall_out, bus_if.req, bus_err_out, flush_at < 0, erd);
        end
        tests++;
        if (stalls !== delay + 2) begin fails++; $display("FAIL %s stall_cycles: got %0d expected %0d", nm, stalls, delay + 2); end
        @(negedge clk);
        mem_enable_in = 1'b0;
        #1;
        tests++;
        if ({bus_if.req, done_out, stall_out} !== 3'b000) begin
            fails++; $display("FAIL %s idle: got req=%b done=%b stall=%b expected 0 0 0", nm, bus_if.req, done_out, stall_out);
        end
    endtask

    task automatic test_reset();
        bus_if.ack = 1'b0; bus_if.rdata = '0;
        repeat (2) @(negedge clk);
        tests++;
        if ({stall_out, addr_error_out, done_out, rdata_out, bus_if.req, bus_if.we, bus_if.addr,
             bus_if.be, bus_if.wdata, bus_err_out} !== '0) begin
            fails++;
            $display("FAIL reset: got stall=%b done=%b rdata=%h req=%b addr=%h be=%b wdata=%h expected all 0",
                     stall_out, done_out, rdata_out, bus_if.req, bus_if.addr, bus_if.be, bus_if.wdata);
        end
        rst_n = 1'b1;
    endtask

    task automatic test_directed();
        do_access(32'h1003, 32'h0, 2'd0, 1'b1, 1'b0, 32'h80FFFFFF, 0, -1, "lb_sext");
        do_access(32'h2002, 32'h0000BEEF, 2'd1, 1'b0, 1'b1, 32'h0, 2, -1, "sh_delay");
        do_access(32'h3001, 32'h0, 2'd2, 1'b0, 1'b0, 32'h0, 0, -1, "lw_misaligned");
        do_access(32'h4002, 32'h0, 2'd1, 1'b0, 1'b0, 32'hABCD1234, 2, 1, "lh_flush");
    endtask

    task automatic test_ack_ignored();
        mem_enable_in = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            bus_if.ack = 1'b1;
            #1;
            tests++;
            if ({bus_if.req, done_out, stall_out} !== 3'b000) begin
                fails++; $display("FAIL ack_idle: got req=%b done=%b stall=%b expected 0 0 0", bus_if.req, done_out, stall_out);
            end
        end
        @(negedge clk);
        bus_if.ack = 1'b0;
    endtask

    task automatic test_flush_idle();
        @(negedge clk);
        addr_in = 32'h5001; mem_width_in = 2'd2; mem_rw_in = 1'b0; mem_enable_in = 1'b1; flush = 1'b1;
        #1;
        tests++;
        if ({addr_error_out, stall_out} !== 2'b00) begin
            fails++; $display("FAIL flush_idle: got err=%b stall=%b expected 0 0", addr_error_out, stall_out);
        end
        @(negedge clk); #1;
        tests++;
        if (bus_if.req !== 1'b0) begin fails++; $display("FAIL flush_idle_req: got %b expected 0", bus_if.req); end
        mem_enable_in = 1'b0; flush = 1'b0;
    endtask

    task automatic test_async_reset();
        @(negedge clk);
        addr_in = 32'h6000; mem_width_in = 2'd2; mem_rw_in = 1'b1; mem_enable_in = 1'b1;
        @(negedge clk);
        mem_enable_in = 1'b0;
        #1;
        tests++;
        if (bus_if.req !== 1'b1) begin fails++; $display("FAIL arst_pre: got req=%b expected 1", bus_if.req); end
        rst_n = 1'b0;
        #1;
        tests++;
        if ({bus_if.req, stall_out} !== 2'b00) begin
            fails++; $display("FAIL arst: got req=%b stall=%b expected 0 0", bus_if.req, stall_out);
        end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_timeout();
`ifdef MEM_TIMEOUT_EN
        @(negedge clk);
        addr_in = 32'h7000; mem_width_in = 2'd2; mem_rw_in = 1'b0; mem_enable_in = 1'b1; bus_if.ack = 1'b0;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk); #1;
            tests++;
            if ({bus_if.req, bus_err_out} !== 2'b10) begin
                fails++; $display("FAIL timeout_wait%0d: got req=%b err=%b expected 1 0", c, bus_if.req, bus_err_out);
            end
        end
        @(negedge clk); #1;
        tests++;
        if ({bus_if.req, bus_err_out, rdata_out} !== {2'b01, 32'd0}) begin
            fails++; $display("FAIL timeout_fire: got req=%b err=%b rdata=%h expected 0 1 0", bus_if.req, bus_err_out, rdata_out);
        end
        mem_enable_in = 1'b0;
        @(negedge clk); #1;
        tests++;
        if ({bus_if.req, bus_err_out} !== 2'b00) begin
            fails++; $display("FAIL timeout_after: got req=%b err=%b expected 0 0", bus_if.req, bus_err_out);
        end
`else
        do_access(32'h7000, 32'h0, 2'd2, 1'b0, 1'b0, 32'h13572468, 9, -1, "long_wait");
`endif
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 30; i++) begin
            int d, f;
            d = $urandom_range(0, 3);
            f = ($urandom_range(0, 3) == 0) ? $urandom_range(0, d) : -1;
            do_access($urandom, $urandom, 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
                      1'($urandom_range(0, 1)), $urandom, d, f, "random");
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_ack_ignored();
        test_flush_idle();
        test_async_reset();
        test_timeout();
        test_back_to_back();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/mem_access_unit.md
# mem_access_unit

Memory-access stage controller that consumes the EX/MEM pipeline register outputs and drives a single-outstanding request/acknowledge data bus. It converts `mem_width`/`sign_extend`/`mem_rw` into byte-lane enables, store-data replication and load-data extraction/extension. It holds the pipeline with `stall_out` until the bus acknowledges.

## Interface
- `ADDR_WIDTH`, 32, address width.
- `DATA_WIDTH`, 32, data width; lane logic is defined for 32 only.
- `TIMEOUT_CYCLES`, 255, watchdog limit in cycles, range 1..65535; used only with `MEM_TIMEOUT_EN`.

Ports:
- `clk` in 1: single clock, rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `flush` in 1: squash the instruction currently at the MEM stage.
- `addr_in` in ADDR_WIDTH: byte address, from `alu_res_out`.
- `wdata_in` in DATA_WIDTH: store data, from `mem_write_out`.
- `mem_width_in` in 2: 0 = byte, 1 = half, 2 = word, 3 = treated as word.
- `sign_extend_in` in 1: 1 = sign-extend loads, 0 = zero-extend.
- `mem_rw_in` in 1: 1 = store, 0 = load.
- `mem_enable_in` in 1: a memory operation is present.
- `stall_out` out 1: hold the pipeline (combinational).
- `addr_error_out` out 1: misaligned access (combinational).
- `done_out` out 1: one-cycle pulse when the access completes.
- `rdata_out` out DATA_WIDTH: aligned and extended load result, valid while `done_out` is high.
- `bus_req` out 1: request; held high until ack.
- `bus_we` out 1: write request.
- `bus_addr` out ADDR_WIDTH: word address `{addr[31:2],2'b00}`.
- `bus_be` out 4: byte enables.
- `bus_wdata` out DATA_WIDTH: lane-replicated store data.
- `bus_ack` in 1: bus completion.
- `bus_rdata` in DATA_WIDTH: read word, sampled on ack.
- `bus_err_out` out 1: timeout pulse (constant 0 without the macro).

## Operation
- FSM states: IDLE, WAIT, DONE. Reset puts the FSM in IDLE, and every registered output is 0.
- Misalignment:
  - A halfword access is misaligned when `addr[0]` = 1.
  - A word access is misaligned when `addr[1:0]` is not 0.
  - `addr_error_out` = IDLE && `mem_enable_in` && !`flush` && misaligned.
  - A misaligned access issues no bus transaction and does not stall.
- `start` = IDLE && `mem_enable_in` && !`flush` && !misaligned.
  - On `start`, the unit latches the address, `be`, replicated wdata, width, sign and rw, then moves to WAIT.
- Byte-lane mapping (little-endian, k = `addr[1:0]`):
  - Byte: `be` = 1<<k, wdata = {4{wdata_in[7:0]}}.
  - Half: `be` = `addr[1]` ? 4'b1100 : 4'b0011, wdata = {2{wdata_in[15:0]}}.
  - Word: `be` = 4'b1111.
  - Loads drive `bus_be` the same way and `bus_wdata` = 0.
- WAIT:
  - `bus_req` = 1; `bus_we`, `bus_addr`, `bus_be` and `bus_wdata` stay stable.
  - On `bus_ack`, the unit captures the extracted, extended lane from `bus_rdata` (0 for stores) into `rdata_out` and moves to DONE.
- DONE:
  - `done_out` = 1 and `stall_out` = 0, so the pipeline advances.
  - The next state is IDLE unconditionally. The stale `mem_enable_in` seen in DONE is never re-issued.
- `stall_out` = `start` || WAIT.
- Flush during WAIT:
  - The bus transaction still completes.
  - A sticky `squash` flag is set. In DONE, `done_out` = 0 and `rdata_out` = 0.
  - `squash` clears in IDLE.
- Reset mid-transaction: `bus_req` drops asynchronously and the FSM goes to IDLE. The bus slave must tolerate the abandoned request.

## Timing
- Minimum access (ack in the first WAIT cycle):
  - Cycle 0: IDLE, `stall_out` = 1.
  - Cycle 1: WAIT, `bus_req` = 1, `bus_ack` = 1.
  - Cycle 2: DONE, `done_out` = 1.
  - Cycle 3: IDLE.
- Each additional wait cycle before ack adds one cycle of stall.
- `bus_ack` is only sampled in WAIT. An ack in IDLE or DONE is ignored.
- `bus_req` rises on the clock edge after `start`, and falls on the clock edge at which ack is sampled.

## Configuration
- `MEM_TIMEOUT_EN` defined:
  - A 16-bit counter clears on entry to WAIT and increments each WAIT cycle without ack.
  - When the count reaches `TIMEOUT_CYCLES`, `bus_req` drops, `bus_err_out` pulses for 1 cycle, and the FSM goes to DONE with `rdata_out` = 0.
- `MEM_TIMEOUT_EN` undefined: no counter; WAIT persists until ack; `bus_err_out` = 0.

## Test plan
- Load byte, `addr` = 0x1003, `sign_extend` = 1, `bus_rdata` = 0x80FFFFFF, ack in the first WAIT cycle -> `bus_addr` = 0x1000, `bus_be` = 4'b1000, `rdata_out` = 0xFFFFFF80, `done_out` in cycle 2, stall in cycles 0–1.
- Store half, `addr` = 0x2002, `wdata` = 0x0000BEEF -> `bus_we` = 1, `bus_be` = 4'b1100, `bus_wdata` = 0xBEEFBEEF; ack delayed 3 cycles -> stall lasts 4 cycles.
- Load word at `addr` = 0x3001 -> `addr_error_out` = 1, `bus_req` stays 0, `stall_out` = 0.
- Load half, `addr` = 0x4002, zero-extend; `flush` asserted in the 2nd WAIT cycle; ack with `bus_rdata` = 0xABCD1234 -> transaction completes, `done_out` = 0, `rdata_out` = 0.
- With `MEM_TIMEOUT_EN` and `TIMEOUT_CYCLES` = 4, no ack -> `bus_req` drops after 4 WAIT cycles, `bus_err_out` pulses once, FSM returns to IDLE; an async reset during WAIT clears `bus_req` immediately.
